// File: rtl/cplx_dly_pkg.sv
// Shared types and helpers for the complex delay line.
// Depth arithmetic and the stage record layout live here.
package cplx_dly_pkg;

  localparam int DATA_W_DEF = 32;

  // Bits needed to hold a depth value 0..max_d.
  function automatic int depth_w(input int max_d);
    return $clog2(max_d + 1);
  endfunction

  // Effective depth: 0 maps to 1, oversize maps to max_d.
  function automatic int clamp_depth(
    input int sel,
    input int max_d
  );
    if (sel < 1)
      return 1;
    if (sel > max_d)
      return max_d;
    return sel;
  endfunction

  // Stage record at the default width.
  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] re;
    logic [DATA_W_DEF-1:0] img;
  } stage_t;

endpackage

// File: rtl/cplx_dly_stage.sv
// One delay-line register: payload moves on en,
// valid moves on en and is cleared by flush.
module cplx_dly_stage
  import cplx_dly_pkg::*;
#(
  parameter int W = 2 * DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  // Payload shifts on en; flush clears only valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else begin
      if (en)
        q_data <= d_data;
      if (flush)
        q_valid <= 1'b0;
      else if (en)
        q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/cplx_delay_line.sv
// Runtime-depth complex delay line with valid, stall and flush.
// Optional macro CPLX_DLY_CONJ_EN adds a conj sideband bit.
module cplx_delay_line
  import cplx_dly_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int MAX_DEPTH = 16,
  parameter  int DEF_DEPTH = 5,
  localparam int DW        = depth_w(MAX_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_img,
`ifdef CPLX_DLY_CONJ_EN
  input  logic              conj,
`endif
  input  logic [DW-1:0]     depth_sel,
  output logic [DATA_W-1:0] a1_re,
  output logic [DATA_W-1:0] a1_img,
  output logic              out_valid
);

`ifdef CPLX_DLY_CONJ_EN
  localparam int PW = 2 * DATA_W + 1;
`else
  localparam int PW = 2 * DATA_W;
`endif

  logic [DW-1:0]        d_eff;
  logic [DW-1:0]        d_q;
  logic                 flush;
  logic                 st0_flush;
  logic [PW-1:0]        in_data;
  logic [MAX_DEPTH-1:0] tap_v;
  logic [PW-1:0]        tap_d [MAX_DEPTH];
  logic                 sel_v;
  logic [PW-1:0]        sel_d;
  logic [DATA_W-1:0]    sel_re;
  logic [DATA_W-1:0]    sel_img;
  logic [DATA_W-1:0]    out_img;

  assign d_eff =
    DW'(clamp_depth(int'(depth_sel), MAX_DEPTH));
  assign flush = (d_eff != d_q);

  // With en high the first stage still takes in_valid.
  assign st0_flush = flush & ~en;

`ifdef CPLX_DLY_CONJ_EN
  assign in_data = {conj, a_re, a_img};
`else
  assign in_data = {a_re, a_img};
`endif

  assign tap_v[0] = in_valid;
  assign tap_d[0] = in_data;

  for (genvar k = 1; k < MAX_DEPTH; k++) begin : g_stage
    cplx_dly_stage #(
      .W (PW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .flush   (k == 1 ? st0_flush : flush),
      .d_valid (tap_v[k-1]),
      .d_data  (tap_d[k-1]),
      .q_valid (tap_v[k]),
      .q_data  (tap_d[k])
    );
  end

  // Pick tap[D-1] for the output register.
  always_comb begin
    sel_v = tap_v[0];
    sel_d = tap_d[0];
    for (int k = 1; k < MAX_DEPTH; k++) begin
      if (int'(d_eff) == k + 1) begin
        sel_v = tap_v[k];
        sel_d = tap_d[k];
      end
    end
  end

  assign sel_re  = sel_d[2*DATA_W-1:DATA_W];
  assign sel_img = sel_d[DATA_W-1:0];

  // Conjugate on the way out; most-negative wraps.
`ifdef CPLX_DLY_CONJ_EN
  assign out_img = sel_d[PW-1] ? DATA_W'(0) - sel_img
                               : sel_img;
`else
  assign out_img = sel_img;
`endif

  // Output register, depth tracking and flush of out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_re     <= '0;
      a1_img    <= '0;
      out_valid <= 1'b0;
      d_q       <= DW'(DEF_DEPTH);
    end else begin
      d_q <= d_eff;
      if (en) begin
        a1_re  <= sel_re;
        a1_img <= out_img;
      end
      if (flush)
        out_valid <= 1'b0;
      else if (en)
        out_valid <= sel_v;
    end
  end

endmodule

// File: tb/tb_cplx_delay_line.sv
// Bench for cplx_delay_line: random streams against a
// history-queue model of the delay line.
module tb_cplx_delay_line;

  localparam int MAX_DEPTH = 16;
  localparam int DEF_DEPTH = 5;
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   a_re = '0;
  logic [31:0]   a_img = '0;
  logic [DW-1:0] depth_sel = DW'(DEF_DEPTH);
  logic [31:0]   a1_re;
  logic [31:0]   a1_img;
  logic          out_valid;
`ifdef CPLX_DLY_CONJ_EN
  logic          conj = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // model: every sample accepted on an enabled edge
  logic [31:0] h_re[$];
  logic [31:0] h_im[$];
  bit          h_v[$];
  bit          h_c[$];
  int          min_idx;
  int          m_dq;
  bit          exp_v;
  logic [31:0] exp_re;
  logic [31:0] exp_im;
  int          en_valid_out;

  cplx_delay_line #(
    .DATA_W    (32),
    .MAX_DEPTH (MAX_DEPTH),
    .DEF_DEPTH (DEF_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .a_re      (a_re),
    .a_img     (a_img),
`ifdef CPLX_DLY_CONJ_EN
    .conj      (conj),
`endif
    .depth_sel (depth_sel),
    .a1_re     (a1_re),
    .a1_img    (a1_img),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic int eff_depth(input int sel);
    if (sel < 1) return 1;
    if (sel > MAX_DEPTH) return MAX_DEPTH;
    return sel;
  endfunction

  task automatic model_reset();
    h_re.delete();
    h_im.delete();
    h_v.delete();
    h_c.delete();
    min_idx = 0;
    m_dq = DEF_DEPTH;
    exp_v = 1'b0;
    exp_re = '0;
    exp_im = '0;
  endtask

  // Drive one cycle, clock it, advance the model.
  task automatic step(
    input bit          e,
    input bit          v,
    input logic [31:0] re,
    input logic [31:0] im,
    input int          sel,
    input bit          cj
  );
    int d;
    int idx;
    bit fl;
    en = e;
    in_valid = v;
    a_re = re;
    a_img = im;
    depth_sel = DW'(sel);
`ifdef CPLX_DLY_CONJ_EN
    conj = cj;
`endif
    @(posedge clk);
    d = eff_depth(sel);
    fl = (d != m_dq);
    m_dq = d;
    if (fl) min_idx = h_v.size();
    if (e) begin
      h_re.push_back(re);
      h_im.push_back(im);
      h_v.push_back(v);
      h_c.push_back(cj);
      idx = h_v.size() - d;
      if (idx >= 0 && idx >= min_idx) begin
        exp_v = h_v[idx];
        exp_re = h_re[idx];
        exp_im = h_im[idx];
`ifdef CPLX_DLY_CONJ_EN
        if (h_c[idx]) exp_im = 32'd0 - h_im[idx];
`endif
      end else begin
        exp_v = 1'b0;
      end
    end
    if (fl) exp_v = 1'b0;
    #1;
    if (e && out_valid) en_valid_out++;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (a1_re !== 32'd0 || a1_img !== 32'd0 ||
        out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: re=%h img=%h v=%b want 0",
               a1_re, a1_img, out_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_default_depth();
    logic [31:0] n32;
    for (int n = 1; n <= 26; n++) begin
      n32 = n;
      if (n <= 20)
        step(1, 1, n32, 32'd0 - n32, 5, 0);
      else
        step(1, 0, 32'd0, 32'd0, 5, 0);
      checks++;
      if (out_valid !== exp_v ||
          (exp_v && (a1_re !== exp_re ||
                     a1_img !== exp_im))) begin
        errors++;
        $display("FAIL default_model n=%0d: v=%b re=%h im=%h want v=%b re=%h im=%h",
                 n, out_valid, a1_re, a1_img,
                 exp_v, exp_re, exp_im);
      end
      checks++;
      if (n < 5 || n > 24) begin
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL default_idle n=%0d: v=%b want 0",
                   n, out_valid);
        end
      end else if (out_valid !== 1'b1 ||
                   a1_re !== n32 - 32'd4 ||
                   a1_img !== 32'd4 - n32) begin
        errors++;
        $display("FAIL default_seq n=%0d: v=%b re=%h im=%h want re=%h",
                 n, out_valid, a1_re, a1_img, n32 - 32'd4);
      end
    end
  endtask

  task automatic test_depth_sweep();
    int sels[5] = '{1, 7, 16, 0, 31};
    int lats[5] = '{1, 7, 16, 1, 16};
    int lat;
    bit found;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 20; i++)
        step(1, 0, $urandom, $urandom, sels[t], 0);
      lat = 0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        if (i == 0)
          step(1, 1, 32'h1234, 32'h0, sels[t], 0);
        else
          step(1, 0, 32'h0, 32'h0, sels[t], 0);
        lat++;
        if (out_valid === 1'b1) found = 1;
      end
      checks++;
      if (!found || lat != lats[t] ||
          a1_re !== 32'h1234) begin
        errors++;
        $display("FAIL sweep sel=%0d: lat=%0d re=%h want lat=%0d re=1234",
                 sels[t], found ? lat : -1, a1_re, lats[t]);
      end
    end
  endtask

  task automatic test_stall();
    int lat;
    bit found;
    int in_cnt;
    bit e;
    bit v;
    for (int i = 0; i < 6; i++)
      step(1, 0, 32'h0, 32'h0, 5, 0);
    lat = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      e = !(i >= 2 && i <= 4);
      if (i == 0)
        step(1, 1, 32'hCAFE, 32'hBEEF, 5, 0);
      else
        step(e, 0, 32'h0, 32'h0, 5, 0);
      lat++;
      if (out_valid === 1'b1) found = 1;
    end
    checks++;
    if (!found || lat != 8 || a1_re !== 32'hCAFE ||
        a1_img !== 32'hBEEF) begin
      errors++;
      $display("FAIL stall_latency: lat=%0d re=%h im=%h want 8 cafe beef",
               found ? lat : -1, a1_re, a1_img);
    end
    for (int i = 0; i < 20; i++)
      step(1, 0, 32'h0, 32'h0, 5, 0);
    en_valid_out = 0;
    in_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      e = (i >= 100) || ($urandom_range(0, 3) != 0);
      v = (i < 100) && ($urandom_range(0, 1) == 1);
      if (e && v) in_cnt++;
      step(e, v, $urandom, $urandom, 5, 0);
      checks++;
      if (out_valid !== exp_v ||
          (exp_v && (a1_re !== exp_re ||
                     a1_img !== exp_im))) begin
        errors++;
        $display("FAIL stall_model i=%0d: v=%b re=%h want v=%b re=%h",
                 i, out_valid, a1_re, exp_v, exp_re);
      end
    end
    checks++;
    if (en_valid_out != in_cnt) begin
      errors++;
      $display("FAIL stall_count: outputs=%0d want %0d",
               en_valid_out, in_cnt);
    end
  endtask

  task automatic test_depth_change();
    for (int i = 0; i < 12; i++)
      step(1, 1, $urandom, $urandom, 8, 0);
    step(1, 1, 32'hABCD, 32'h77, 3, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL change_flush: v=%b want 0", out_valid);
    end
    step(1, 0, 32'h0, 32'h0, 3, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL change_gap: v=%b want 0", out_valid);
    end
    step(1, 0, 32'h0, 32'h0, 3, 0);
    checks++;
    if (out_valid !== 1'b1 || a1_re !== 32'hABCD ||
        a1_img !== 32'h77) begin
      errors++;
      $display("FAIL change_first: v=%b re=%h im=%h want 1 abcd 77",
               out_valid, a1_re, a1_img);
    end
    for (int i = 0; i < 6; i++)
      step(1, 1, $urandom, $urandom, 3, 0);
    step(0, 1, 32'h0, 32'h0, 6, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL change_stalled: v=%b want 0", out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 1, $urandom, $urandom, 6, 0);
      checks++;
      if (out_valid !== exp_v ||
          (exp_v && a1_re !== exp_re)) begin
        errors++;
        $display("FAIL change_model i=%0d: v=%b re=%h want v=%b re=%h",
                 i, out_valid, a1_re, exp_v, exp_re);
      end
    end
  endtask

  task automatic test_async_reset();
    int lat;
    bit found;
    for (int i = 0; i < 10; i++)
      step(1, 1, $urandom | 32'h1, $urandom | 32'h1, 5, 0);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (a1_re !== 32'd0 || a1_img !== 32'd0 ||
        out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: re=%h im=%h v=%b want 0",
               a1_re, a1_img, out_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step(1, 0, 32'h0, 32'h0, 5, 0);
    lat = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (i == 0)
        step(1, 1, 32'h5A5A, 32'hA5A5, 5, 0);
      else
        step(1, 0, 32'h0, 32'h0, 5, 0);
      lat++;
      if (out_valid === 1'b1) found = 1;
    end
    checks++;
    if (!found || lat != DEF_DEPTH ||
        a1_re !== 32'h5A5A) begin
      errors++;
      $display("FAIL reset_latency: lat=%0d re=%h want %0d 5a5a",
               found ? lat : -1, a1_re, DEF_DEPTH);
    end
  endtask

  task automatic test_random();
    int sel;
    bit e;
    bit v;
    sel = 5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0)
        sel = $urandom_range(0, 31);
      e = ($urandom_range(0, 4) != 0);
      v = ($urandom_range(0, 9) < 7);
      step(e, v, $urandom, $urandom, sel, 1'($urandom));
      checks++;
      if (out_valid !== exp_v ||
          (exp_v && (a1_re !== exp_re ||
                     a1_img !== exp_im))) begin
        errors++;
        $display("FAIL random i=%0d sel=%0d: v=%b re=%h im=%h want v=%b re=%h im=%h",
                 i, sel, out_valid, a1_re, a1_img,
                 exp_v, exp_re, exp_im);
      end
    end
  endtask

`ifdef CPLX_DLY_CONJ_EN
  task automatic test_conj();
    logic [31:0] ims[2] = '{32'd5, 32'h80000000};
    logic [31:0] want[2] = '{32'hFFFFFFFB, 32'h80000000};
    int lat;
    bit found;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 8; i++)
        step(1, 0, 32'h0, 32'h0, 4, 0);
      lat = 0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        if (i == 0)
          step(1, 1, 32'h9, ims[t], 4, 1);
        else
          step(1, 0, 32'h0, 32'h0, 4, 0);
        lat++;
        if (out_valid === 1'b1) found = 1;
      end
      checks++;
      if (!found || lat != 4 || a1_img !== want[t] ||
          a1_re !== 32'h9) begin
        errors++;
        $display("FAIL conj t=%0d: lat=%0d im=%h want 4 %h",
                 t, found ? lat : -1, a1_img, want[t]);
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_default_depth();
    test_depth_sweep();
    test_stall();
    test_depth_change();
    test_async_reset();
    test_random();
`ifdef CPLX_DLY_CONJ_EN
    test_conj();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
